// File: rtl/dac_transmitter_pkg.sv
// Shared frame/format constants for the I2S DAC transmitter.
// Default sample width and the sample type used by the serialiser and its bench.
package dac_transmitter_pkg;

    localparam int DEFAULT_WIDTH    = 24;
    localparam int DEFAULT_HALF_DIV = 1;

    typedef logic [DEFAULT_WIDTH-1:0] sample_t;

    // Width of a slot counter covering 2*width slots of one stereo frame.
    function automatic int slot_bits(input int width);
        return (width > 0) ? $clog2(2 * width) : 1;
    endfunction

endpackage

// File: rtl/dac_transmitter_clk_div.sv
// sclk divider: produces a registered sclk and a strobe on the cycle that enters a new slot.
// first_slot marks a slot entry that starts from idle (after reset or while enable was low).
module dac_clk_div
    import dac_transmitter_pkg::*;
#(
    parameter int HALF_DIV = DEFAULT_HALF_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic sclk,
    output logic slot_start,
    output logic first_slot
);

    localparam int PH_W = $clog2(2 * HALF_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * HALF_DIV - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(HALF_DIV);

    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] phase_inc;
    logic            running;

    always_comb begin
        phase_inc  = phase + PH_W'(1);
        first_slot = !rst && enable && !running;
        slot_start = !rst && enable && (!running || phase == PH_LAST);
    end

    // phase counts clk cycles inside a slot; sclk is low for the first half.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            phase   <= '0;
            running <= 1'b0;
            sclk    <= 1'b0;
        end else if (slot_start) begin
            phase   <= '0;
            running <= 1'b1;
            sclk    <= 1'b0;
        end else begin
            phase   <= phase_inc;
            sclk    <= (phase_inc >= PH_HIGH);
        end
    end

endmodule

// File: rtl/dac_transmitter.sv
// Stereo I2S serialiser: one left/right sample pair per frame, MSB first, all outputs registered.
// Define DAC_LEFT_JUSTIFIED_EN for left-justified format (no one-bit delay); default is standard I2S.
module dac_transmitter
    import dac_transmitter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int HALF_DIV = DEFAULT_HALF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] left_data,
    input  logic [WIDTH-1:0] right_data,
    output logic             sclk,
    output logic             lrclk,
    output logic             sd
);

    localparam int SLOTS  = 2 * WIDTH;
    localparam int SLOT_W = slot_bits(WIDTH);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] RIGHT_SLOT = SLOT_W'(WIDTH);

    logic              slot_start;
    logic              first_slot;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] next_slot;
    logic [SLOT_W-1:0] bit_idx;
    logic [WIDTH-1:0]  left_q;
    logic [WIDTH-1:0]  right_q;
    logic [SLOTS-1:0]  word_nxt;
    logic              sd_nxt;

    dac_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_div (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sclk       (sclk),
        .slot_start (slot_start),
        .first_slot (first_slot)
    );

    // Slot 0 reads the incoming samples because they are latched on that same edge.
    always_comb begin
        next_slot = '0;
        if (!first_slot && slot != LAST_SLOT) begin
            next_slot = slot + SLOT_W'(1);
        end
        word_nxt = (next_slot == '0) ? {left_data, right_data} : {left_q, right_q};
`ifdef DAC_LEFT_JUSTIFIED_EN
        bit_idx = LAST_SLOT - next_slot;
        sd_nxt  = word_nxt[bit_idx];
`else
        // One-bit delay: slot s carries word bit SLOTS-s, slot 0 the previous right LSB.
        bit_idx = LAST_SLOT - next_slot + SLOT_W'(1);
        if (next_slot == '0) begin
            sd_nxt = first_slot ? 1'b0 : right_q[0];
        end else begin
            sd_nxt = word_nxt[bit_idx];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot    <= '0;
            lrclk   <= 1'b0;
            sd      <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
        end else if (!enable) begin
            slot    <= '0;
            lrclk   <= 1'b0;
            sd      <= 1'b0;
        end else if (slot_start) begin
            slot  <= next_slot;
            lrclk <= (next_slot >= RIGHT_SLOT);
            sd    <= sd_nxt;
            if (next_slot == '0) begin
                left_q  <= left_data;
                right_q <= right_data;
            end
        end
    end

endmodule

// File: tb/tb_dac_transmitter.sv
// Self-checking bench for dac_transmitter: vector table, directed frame sequences,
// randomized traffic against a frame-level reference model, and a divider check on a second instance.
module tb_dac_transmitter;
    import dac_transmitter_pkg::*;

    localparam int W  = DEFAULT_WIDTH;
    localparam int H  = DEFAULT_HALF_DIV;
    localparam int FL = 4 * W * H;
    localparam int W2 = 16;
    localparam int H2 = 3;
`ifdef DAC_LEFT_JUSTIFIED_EN
    localparam bit LJ_MODE = 1'b1;
`else
    localparam bit LJ_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic    rst = 1'b1;
    logic    enable = 1'b1;
    sample_t left_data = '0;
    sample_t right_data = '0;
    logic    sclk, lrclk, sd;

    logic          rst2 = 1'b1;
    logic          en2 = 1'b1;
    logic [W2-1:0] left2 = 16'hC3A5;
    logic [W2-1:0] right2 = 16'h5A3D;
    logic          sclk2, lrclk2, sd2;

    dac_transmitter dut (
        .clk(clk), .rst(rst), .enable(enable), .left_data(left_data),
        .right_data(right_data), .sclk(sclk), .lrclk(lrclk), .sd(sd)
    );

    dac_transmitter #(.WIDTH(W2), .HALF_DIV(H2)) dut2 (
        .clk(clk), .rst(rst2), .enable(en2), .left_data(left2),
        .right_data(right2), .sclk(sclk2), .lrclk(lrclk2), .sd(sd2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: position in frame -> slot; the frame's bit string is fixed at frame start.
    logic           m_run = 1'b0;
    int             m_t = 0;
    logic [2*W-1:0] m_word = '0;
    sample_t        m_r = '0;
    logic           m_sclk = 1'b0, m_lr = 1'b0, m_sd = 1'b0;

    task automatic model_update(input logic r_v, input logic e_v, input sample_t l, input sample_t r);
        logic carry;
        int   slot_n;
        if (r_v || !e_v) begin
            m_run = 1'b0;
            m_sclk = 1'b0;
            m_lr = 1'b0;
            m_sd = 1'b0;
            return;
        end
        carry = 1'b0;
        if (!m_run) m_t = 0;
        else if (m_t == FL - 1) begin
            m_t = 0;
            carry = m_r[0];
        end else m_t++;
        m_run = 1'b1;
        if (m_t == 0) begin
            m_r = r;
`ifdef DAC_LEFT_JUSTIFIED_EN
            m_word = {l, r};
`else
            m_word = {carry, l, r[W-1:1]};
`endif
        end
        slot_n = m_t / (2 * H);
        m_sclk = ((m_t % (2 * H)) >= H);
        m_lr = (slot_n >= W);
        m_sd = m_word[2*W-1-slot_n];
    endtask

    task automatic step(input logic r_v, input logic e_v, input sample_t l, input sample_t r);
        rst = r_v;
        enable = e_v;
        left_data = l;
        right_data = r;
        @(posedge clk);
        model_update(r_v, e_v, l, r);
        @(negedge clk);
        check("model_sclk", sclk, m_sclk);
        check("model_lrclk", lrclk, m_lr);
        check("model_sd", sd, m_sd);
    endtask

    typedef struct {
        logic    r_v;
        logic    e_v;
        sample_t l;
        sample_t r;
        logic    s;
        logic    lr;
        logic    d;
    } vec_t;

    vec_t vecs[9];
    logic exp_q[$];

    initial begin
        sample_t l_a, r_a;
        logic [2*W2-1:0] word2;
        logic exp_bit;
        int gap;
        l_a = 24'hA5F00F;
        r_a = 24'h3C0FF1;

        // Reset for 3 cycles with enable high, then the first slots of the first frame.
        for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 1'b1, l_a, r_a, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, l_a, r_a, 1'b0, 1'b0, LJ_MODE ? 1'b1 : 1'b0};
        vecs[4] = '{1'b0, 1'b1, l_a, r_a, 1'b1, 1'b0, LJ_MODE ? 1'b1 : 1'b0};
        vecs[5] = '{1'b0, 1'b1, l_a, r_a, 1'b0, 1'b0, LJ_MODE ? 1'b0 : 1'b1};
        vecs[6] = '{1'b0, 1'b1, l_a, r_a, 1'b1, 1'b0, LJ_MODE ? 1'b0 : 1'b1};
        vecs[7] = '{1'b0, 1'b1, l_a, r_a, 1'b0, 1'b0, LJ_MODE ? 1'b1 : 1'b0};
        vecs[8] = '{1'b0, 1'b1, l_a, r_a, 1'b1, 1'b0, LJ_MODE ? 1'b1 : 1'b0};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].r_v, vecs[i].e_v, vecs[i].l, vecs[i].r);
            check("tbl_sclk", sclk, vecs[i].s);
            check("tbl_lrclk", lrclk, vecs[i].lr);
            check("tbl_sd", sd, vecs[i].d);
        end

        // Rest of frame 1; left changes to zero from slot 5 and must not disturb it.
        for (int t = 6; t < FL; t++) begin
            step(1'b0, 1'b1, (t >= 10) ? 24'h000000 : l_a, r_a);
            if (t == W * 2 * H) check("lrclk_rise", lrclk, 1'b1);
            if (t == W * 2 * H - 1) check("lrclk_left_end", lrclk, 1'b0);
        end
        step(1'b0, 1'b1, 24'h000000, r_a);
        check("wrap_sd", sd, LJ_MODE ? 1'b0 : 1'b1);
        check("wrap_lrclk", lrclk, 1'b0);
        check("wrap_sclk", sclk, 1'b0);

        // Frame 2 up to slot 30, then enable low for 10 cycles.
        for (int t = 1; t < 30 * 2 * H; t++) step(1'b0, 1'b1, 24'h000000, r_a);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 24'h800001, r_a);
            check("gate_sclk", sclk, 1'b0);
            check("gate_lrclk", lrclk, 1'b0);
            check("gate_sd", sd, 1'b0);
        end

        // Re-enable: new frame at slot 0 with left=800001.
        step(1'b0, 1'b1, 24'h800001, r_a);
        check("reen_sd", sd, LJ_MODE ? 1'b1 : 1'b0);
        check("reen_lrclk", lrclk, 1'b0);
        for (int t = 1; t <= FL; t++) step(1'b0, 1'b1, 24'h800001, 24'h000000);

        // Randomized traffic with occasional disable gaps and resets.
        gap = 0;
        for (int i = 0; i < 700; i++) begin
            if (gap == 0 && $urandom_range(0, 79) == 0) gap = $urandom_range(1, 5);
            if ($urandom_range(0, 299) == 0)
                step(1'b1, 1'b1, sample_t'($urandom), sample_t'($urandom));
            else
                step(1'b0, (gap == 0), sample_t'($urandom), sample_t'($urandom));
            if (gap > 0) gap--;
        end

        // Divider check on the WIDTH=16, HALF_DIV=3 instance.
        enable = 1'b0;
        rst2 = 1'b0;
`ifdef DAC_LEFT_JUSTIFIED_EN
        word2 = {left2, right2};
`else
        word2 = {1'b0, left2, right2[W2-1:1]};
`endif
        for (int s = 0; s < 2 * W2; s++) exp_q.push_back(word2[2*W2-1-s]);
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            @(negedge clk);
            check("div_sclk", sclk2, ((t % (2 * H2)) >= H2));
            check("div_lrclk", lrclk2, ((t % (4 * W2 * H2)) >= 2 * W2 * H2));
            if ((t % (2 * H2)) == H2 && t < 4 * W2 * H2) begin
                if (exp_q.size() == 0) check("div_sd_queue", 1'b1, 1'b0);
                else begin
                    exp_bit = exp_q.pop_front();
                    check("div_sd", sd2, exp_bit);
                end
            end
        end
        check("div_queue_empty", (exp_q.size() == 0), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_transmitter.md
Name: dac_transmitter

Overview:
- Serialises one stereo PCM sample pair per frame onto a 3-wire I2S bus (sclk, lrclk, sd) that drives the external audio DAC through the ja header.
- Sits after the oscillator/mixer stage in top.
- Runs in a single clock domain and generates sclk internally by division.
- Default format is standard I2S, 24-bit, MSB first.

Parameters:
- WIDTH, 24: bits per channel sample; frame length is 2*WIDTH sclk periods.
- HALF_DIV, 1: clk cycles per sclk half-period (sclk = clk/(2*HALF_DIV)); legal values are ≥1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  when low, the bus is held idle and the frame restarts.
- left_data  input  WIDTH  left sample, two's complement; sampled only at frame start.
- right_data  input  WIDTH  right sample, two's complement; sampled only at frame start.
- sclk  output  1  serial bit clock; the DAC samples sd on its rising edge.
- lrclk  output  1  word select; 0 = left, 1 = right.
- sd  output  1  serial data, MSB first; changes only on sclk falling edges.

Behaviour:
- Reset values (rst=1 at a posedge): sclk=0, lrclk=0, sd=0. Divider, slot counter and latched samples are all cleared, and the stored previous-right-LSB is 0. Reset wins over enable.
- enable=0 (rst=0): same idle values as reset, except latched data is retained. The next enable=1 cycle starts a new frame at slot 0.
- All outputs are registered (no combinational input-to-output paths).
- Frame timing:
  - Slots 0..2*WIDTH-1, each 2*HALF_DIV clk cycles: sclk low for the first HALF_DIV cycles, high for the second.
  - Frame length is 4*WIDTH*HALF_DIV cycles (96 at defaults).
- Slot entry (the slot's falling edge, or its first enabled cycle): lrclk, sd and the slot counter update. lrclk = 0 for slots 0..WIDTH-1 and 1 for slots WIDTH..2*WIDTH-1.
- Latching:
  - At slot 0 entry, left_data and right_data are captured together.
  - Input changes at any other time do not affect the current frame.
- sd, I2S format (one-bit delay):
  - slot 0: LSB of the previous frame's right sample.
  - slots 1..WIDTH: left[WIDTH-1]..left[0].
  - slots WIDTH+1..2*WIDTH-1: right[WIDTH-1]..right[1].
  - right[0] goes out in slot 0 of the next frame. After reset or disable it is 0.
- Wrap-around: after slot 2*WIDTH-1 the counter returns to 0 with no gap. New data is latched in the same cycle.
- Enable dropped mid-frame: the outputs go idle on the next posedge. The partial frame is abandoned, and the pending right LSB is cleared to 0.
- rst asserted mid-frame: the block is idle on the next posedge, with the same values as above.

Optional Feature:
- DAC_LEFT_JUSTIFIED_EN
  - Defined: left-justified format with no one-bit delay.
    - Slot k (0..WIDTH-1) carries left[WIDTH-1-k].
    - Slot WIDTH+k carries right[WIDTH-1-k].
    - No carry-over bit.
  - Undefined: I2S format as above.
  - lrclk timing is identical in both modes.

Decomposition:
- Shared package: frame/format constants (default sample width 24, the SAMPLE_T typedef logic [23:0]) in the existing constants.svh/protocol_pkg.
- One natural sub-module: dac_clk_div, the sclk divider that produces a sclk register plus a one-cycle "slot_start" strobe. The serialiser (counter, shift registers, lrclk) stays in dac_transmitter.

Test Plan:
- Reset: rst=1 for 3 cycles with enable=1 -> sclk=0, lrclk=0, sd=0 every cycle; the first frame starts on the first cycle after rst falls.
- Single frame (defaults): left=24'hA5F00F, right=24'h3C0FF1, enable=1.
  - sd captured on sclk rising edges reads 0, then A5F00F MSB-first, then bits 23..1 of 3C0FF1.
  - lrclk=0 for 24 slots, then 1 for 24 slots.
  - Next frame slot 0 sd=1 (right LSB).
  - Period is 96 clk cycles.
- Latch isolation: change left_data to 24'h000000 at slot 5 -> the current frame still shifts A5F00F; the new value appears only in the next frame.
- Enable gating: deassert enable at slot 30 for 10 cycles -> outputs idle (0,0,0); on re-enable a full new frame starts at slot 0 with sd=0 in slot 0.
- Divider: HALF_DIV=3, WIDTH=16 -> sclk high and low each 3 cycles, frame length 192 cycles, lrclk toggles every 96 cycles.
- Left-justified build (DAC_LEFT_JUSTIFIED_EN defined), left=24'h800001 -> slot 0 sd=1, slots 1..22 sd=0, slot 23 sd=1, with no delay bit.
